// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared types and constants for the register-bank/ULA responder
package reg_bank_pkg;
  localparam int NUM_REGS   = 4;
  localparam int DATA_W     = 16;
  localparam int OUT_W      = 32;
  localparam int MUL_CYCLES = 16;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_AND = 2'b11} op_e;
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_e;
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one partial product per cycle, W cycles per product
module seq_multiplier #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W);
  logic [2*W-1:0] mcand_q, mcand_d, acc_q, acc_d, step;
  logic [W-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d;
  // product is the final step's sum so the caller can register it on the done edge
  always_comb begin
    step     = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = run_q && cnt_q == CW'(W - 1);
    product  = step;
    run_d    = start ? 1'b1 : done ? 1'b0 : run_q;
    mcand_d  = start ? {W'(0), a} : run_q ? mcand_q << 1 : mcand_q;
    mplier_d = start ? b : run_q ? mplier_q >> 1 : mplier_q;
    acc_d    = start ? '0 : run_q ? step : acc_q;
    cnt_d    = start ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end
endmodule

// File: rtl/reg_bank_ula.sv
// reg_bank_ula: four-entry register file plus ALU responder with registered 32-bit result and valid pulse
module reg_bank_ula
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_reg,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_ula,
  input  logic [DATA_W-1:0] A,
  input  logic [1:0]        reg_sel,
  input  logic [1:0]        instru,
  output logic [OUT_W-1:0]  data_out,
  output logic              valid_out,
  output logic              busy
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  state_e state_q, state_d;
  logic [OUT_W-1:0] data_out_q, data_out_d, alu_res;
  logic valid_out_q, valid_out_d, busy_q, busy_d;
  logic [DATA_W-1:0] opnd_r;
  logic [2*DATA_W-1:0] mul_product;
  logic accept, mul_start, mul_done;
  op_e op;
  assign op        = op_e'(instru);
  assign opnd_r    = regs_q[reg_sel];
  assign accept    = valid_ula && state_q == IDLE;
  assign mul_start = accept && op == OP_MUL;
  assign alu_res   = op == OP_ADD ? OUT_W'(A) + OUT_W'(opnd_r) :
                     op == OP_SUB ? OUT_W'(A) - OUT_W'(opnd_r) : OUT_W'(A & opnd_r);
  seq_multiplier #(.W(DATA_W)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(mul_start),
    .a(A),
    .b(opnd_r),
    .done(mul_done),
    .product(mul_product)
  );
  // operand R is read from regs_q, so a same-edge write is seen only by later requests
  always_comb begin
    regs_d = regs_q;
    if (valid_reg) regs_d[addr] = data_in;
    state_d     = state_q == IDLE ? (mul_start ? MUL : IDLE) : (mul_done ? IDLE : MUL);
    valid_out_d = (accept && !mul_start) || (state_q == MUL && mul_done);
    data_out_d  = accept && !mul_start ? alu_res :
                  state_q == MUL && mul_done ? OUT_W'(mul_product) : data_out_q;
    busy_d      = state_d == MUL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q      <= '{default: '0};
      state_q     <= IDLE;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
    end
  end
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign busy      = busy_q;
endmodule
